// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo motion scheduler.
package servo_pkg;

   localparam int POS_W          = 8;
   localparam int CH_IDX_W       = 4;
   localparam int CENTER_DEFAULT = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } sched_state_e;

   // Next position of one channel after a single frame step toward its target.
   // A step of 0 means "jump straight to target".
   function automatic logic [POS_W-1:0] slew_next(
      input logic [POS_W-1:0] pos,
      input logic [POS_W-1:0] tgt,
      input logic [POS_W-1:0] step
   );
      logic [POS_W:0]   d;
      logic [POS_W-1:0] res;
      res = pos;
      if (tgt > pos) d = {1'b0, tgt} - {1'b0, pos};
      else           d = {1'b0, pos} - {1'b0, tgt};
      if (pos != tgt) begin
         if ((step == '0) || (d <= {1'b0, step})) res = tgt;
         else if (tgt > pos)                      res = pos + step;
         else                                     res = pos - step;
      end
      return res;
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; tick marks the last cycle of every frame.
module servo_frame_timer #(
   parameter int FRAME_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == CW'(FRAME_CYCLES - 1));

   // Count 0..FRAME_CYCLES-1 and wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt_q <= '0;
      else if (tick) cnt_q <= '0;
      else           cnt_q <= cnt_q + CW'(1);
   end

endmodule

// File: rtl/servo_motion_scheduler.sv
// Per-frame motion sequencer for a bank of PWM servo channels.
//
// Command port handshake: a command transfers on a rising clk edge where
// cmd_valid and cmd_ready are both 1. cmd_ready depends only on the FSM state
// (high in IDLE), never on cmd_valid. The master must hold its command stable
// while cmd_valid is high and cmd_ready is low.
module servo_motion_scheduler
   import servo_pkg::*;
#(
   parameter int NCH          = 4,
   parameter int FRAME_CYCLES = 1000000,
   parameter int CENTER       = CENTER_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CH_IDX_W-1:0]   cmd_ch,
   input  logic [POS_W-1:0]      cmd_target,
   input  logic [POS_W-1:0]      cmd_step,
   input  logic                  cmd_en,
   output logic [NCH*POS_W-1:0]  pos_out,
   output logic [NCH-1:0]        ch_enable,
   output logic [NCH-1:0]        settled,
   output logic                  frame_done,
   output logic                  cmd_err,
   output sched_state_e          state_dbg
);

   localparam logic [POS_W-1:0]    CENTER_C = POS_W'(CENTER);
   localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(NCH - 1);

   logic [POS_W-1:0]    pos_q  [NCH];
   logic [POS_W-1:0]    tgt_q  [NCH];
   logic [POS_W-1:0]    step_q [NCH];
   logic [NCH-1:0]      en_q;
   sched_state_e        state_q, state_d;
   logic [CH_IDX_W-1:0] idx_q;
   logic                tick;
   logic                hs;
   logic                ch_ok;

   servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign hs        = cmd_valid & cmd_ready;
   assign ch_ok     = ({{(32-CH_IDX_W){1'b0}}, cmd_ch} < 32'(NCH));
   assign ch_enable = en_q;
   assign state_dbg = state_q;

   // FSM next state and state-decoded outputs.
   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (tick) state_d = UPDATE;
         end
         UPDATE: begin
            if (idx_q == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register and update-pass channel index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == UPDATE) idx_q <= idx_q + CH_IDX_W'(1);
         else                   idx_q <= '0;
      end
   end

   // Channel registers: command writes in IDLE, one slew step per UPDATE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            pos_q[i]  <= CENTER_C;
            tgt_q[i]  <= CENTER_C;
            step_q[i] <= '0;
         end
         en_q    <= '0;
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= hs & ~ch_ok;
         for (int i = 0; i < NCH; i++) begin
            if (hs && ch_ok && (cmd_ch == CH_IDX_W'(i))) begin
               tgt_q[i]  <= cmd_target;
               step_q[i] <= cmd_step;
               en_q[i]   <= cmd_en;
               if ((cmd_step == '0) && cmd_en) pos_q[i] <= cmd_target;
            end else if ((state_q == UPDATE) && (idx_q == CH_IDX_W'(i)) && en_q[i]) begin
               pos_q[i] <= slew_next(pos_q[i], tgt_q[i], step_q[i]);
            end
         end
      end
   end

   // Pack positions for the PWM bank and flag channels that reached target.
   always_comb begin
      pos_out = '0;
      settled = '0;
      for (int i = 0; i < NCH; i++) begin
         pos_out[POS_W*i +: POS_W] = pos_q[i];
         settled[i]                = (pos_q[i] == tgt_q[i]);
      end
   end

endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Bench for servo_motion_scheduler: directed steps followed by random commands,
// checked every cycle against a frame-timing reference model.
module tb_servo_motion_scheduler;
   import servo_pkg::*;

   localparam int NCH = 4;
   localparam int F   = 16;
   localparam int C   = 128;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [3:0]         cmd_ch = '0;
   logic [7:0]         cmd_target = '0;
   logic [7:0]         cmd_step = '0;
   logic               cmd_en = 1'b0;
   logic [NCH*8-1:0]   pos_out;
   logic [NCH-1:0]     ch_enable;
   logic [NCH-1:0]     settled;
   logic               frame_done;
   logic               cmd_err;
   sched_state_e       state_dbg;

   int vecs  = 0;
   int fails = 0;

   // reference model state
   int m_pos [NCH];
   int m_tgt [NCH];
   int m_step[NCH];
   bit m_en  [NCH];
   int cyc;      // rising edges since reset release
   bit m_err;
   int lows;

   servo_motion_scheduler #(.NCH(NCH), .FRAME_CYCLES(F), .CENTER(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .cmd_en     (cmd_en),
      .pos_out    (pos_out),
      .ch_enable  (ch_enable),
      .settled    (settled),
      .frame_done (frame_done),
      .cmd_err    (cmd_err),
      .state_dbg  (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame n (n>=1) ticks on the last cycle of frame n-1; the pass then takes
   // the first NCH cycles of the next frame, followed by the done cycle.
   function automatic bit m_upd_cycle();
      return (cyc >= F) && ((cyc % F) < NCH);
   endfunction

   function automatic bit m_done_cycle();
      return (cyc >= F) && ((cyc % F) == NCH);
   endfunction

   function automatic bit m_ready();
      return !(m_upd_cycle() || m_done_cycle());
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_pos[i] = C; m_tgt[i] = C; m_step[i] = 0; m_en[i] = 1'b0;
      end
      cyc   = 0;
      m_err = 1'b0;
   endtask

   // Apply to the model what the coming rising edge does.
   task automatic model_edge();
      bit err_n;
      int k, diff, mag;
      err_n = 1'b0;
      if (cmd_valid && m_ready()) begin
         if (int'(cmd_ch) < NCH) begin
            m_tgt[cmd_ch]  = int'(cmd_target);
            m_step[cmd_ch] = int'(cmd_step);
            m_en[cmd_ch]   = cmd_en;
            if (cmd_step == 8'd0 && cmd_en) m_pos[cmd_ch] = int'(cmd_target);
         end else begin
            err_n = 1'b1;
         end
      end
      if (m_upd_cycle()) begin
         k    = cyc % F;
         diff = m_tgt[k] - m_pos[k];
         mag  = (diff < 0) ? -diff : diff;
         if (m_en[k] && diff != 0) begin
            if (m_step[k] == 0 || mag <= m_step[k]) m_pos[k] = m_tgt[k];
            else if (diff > 0)                      m_pos[k] = m_pos[k] + m_step[k];
            else                                    m_pos[k] = m_pos[k] - m_step[k];
         end
      end
      m_err = err_n;
      cyc++;
   endtask

   task automatic check_all();
      logic [63:0] ep, es, ee;
      sched_state_e est;
      ep = '0; es = '0; ee = '0;
      for (int i = 0; i < NCH; i++) begin
         ep[8*i +: 8] = 8'(m_pos[i]);
         es[i]        = (m_pos[i] == m_tgt[i]);
         ee[i]        = m_en[i];
      end
      est = m_upd_cycle() ? UPDATE : (m_done_cycle() ? DONE : IDLE);
      chk("pos_out",    pos_out,    ep);
      chk("settled",    settled,    es);
      chk("ch_enable",  ch_enable,  ee);
      chk("cmd_ready",  cmd_ready,  m_ready());
      chk("frame_done", frame_done, m_done_cycle());
      chk("cmd_err",    cmd_err,    m_err);
      chk("state",      state_dbg,  est);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic to_frame_done();
      int guard;
      guard = 0;
      cycle();
      while (!m_done_cycle() && guard < 2*F) begin
         cycle();
         guard++;
      end
   endtask

   // Offer a command and hold it until accepted; returns cycles seen with ready low.
   task automatic send(input int ch, input int tgt, input int step, input bit en,
                       output int low_cnt);
      int guard;
      cmd_valid  = 1'b1;
      cmd_ch     = 4'(ch);
      cmd_target = 8'(tgt);
      cmd_step   = 8'(step);
      cmd_en     = en;
      low_cnt    = 0;
      guard      = 0;
      while (!m_ready() && guard < 4*F) begin
         if (cmd_ready === 1'b0) low_cnt++;
         cycle();
         guard++;
      end
      cycle();
      cmd_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all();
      chk("reset_pos", pos_out, 32'h80808080);
      chk("reset_settled", settled, 4'hF);

      // first frame_done lands F+NCH edges after release
      run(F + NCH);
      chk("first_frame_done", frame_done, 1'b1);

      // slew ch0 128 -> 140 by 5 per frame
      send(0, 140, 5, 1'b1, lows);
      to_frame_done();
      chk("ch0_frame1", pos_out[7:0], 8'd133);
      chk("ch0_unsettled", settled[0], 1'b0);
      to_frame_done();
      chk("ch0_frame2", pos_out[7:0], 8'd138);
      to_frame_done();
      chk("ch0_frame3", pos_out[7:0], 8'd140);
      chk("ch0_settled", settled[0], 1'b1);

      // step 0 jumps on the handshake edge
      send(2, 10, 0, 1'b1, lows);
      chk("ch2_jump", pos_out[23:16], 8'd10);
      chk("ch2_settled", settled[2], 1'b1);

      // disabled channel holds, then resumes when enabled
      send(1, 200, 10, 1'b0, lows);
      to_frame_done(); to_frame_done(); to_frame_done();
      chk("ch1_held", pos_out[15:8], 8'd128);
      chk("ch1_unsettled", settled[1], 1'b0);
      send(1, 200, 10, 1'b1, lows);
      to_frame_done();
      chk("ch1_resume", pos_out[15:8], 8'd138);

      // valid held from the first UPDATE cycle: ready low NCH+1 cycles
      while (!(cyc >= F && (cyc % F) == 0)) cycle();
      send(3, 50, 7, 1'b1, lows);
      chk("ready_low_cycles", 64'(lows), 64'(NCH + 1));

      // out-of-range channel
      send(7, 99, 3, 1'b1, lows);
      chk("bad_ch_err", cmd_err, 1'b1);
      cycle();
      chk("bad_ch_err_clear", cmd_err, 1'b0);

      // reset mid-UPDATE
      while (!(cyc >= F && (cyc % F) == 1)) cycle();
      rst_n = 1'b0;
      #1;
      chk("rst_pos", pos_out, 32'h80808080);
      chk("rst_enable", ch_enable, 4'h0);
      chk("rst_settled", settled, 4'hF);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_cmd_err", cmd_err, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all();

      // random commands
      for (int n = 0; n < 60; n++) begin
         int ch, tgt, step;
         bit en;
         run($urandom_range(0, 12));
         ch   = ($urandom_range(0, 9) == 0) ? $urandom_range(NCH, 15) : $urandom_range(0, NCH - 1);
         tgt  = $urandom_range(0, 255);
         step = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
         en   = ($urandom_range(0, 3) != 0);
         send(ch, tgt, step, en, lows);
      end
      run(4 * F);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
